// File: rtl/hdl_utils_pkg.sv
// Shared helpers for the data_pack slice: counter sizing for word-packing ratios.
package hdl_utils_pkg;

  function automatic int cnt_w(input int ratio);
    return $clog2(ratio);
  endfunction

endpackage

// File: rtl/data_pack_if.sv
// Narrow-in / wide-out stream bus for data_pack.
// DATA_PACK_LAST_EN adds in_last_i, out_last_o and out_cnt_o for early group completion.
interface data_pack_if #(
  parameter int WIDTH = 32,
  parameter int RATIO = 4
);
  import hdl_utils_pkg::*;

  logic [WIDTH-1:0]       in_data_i;
  logic                   in_valid_i;
  logic                   in_ready_o;
  logic [WIDTH*RATIO-1:0] out_data_o;
  logic                   out_valid_o;
  logic                   out_ready_i;

`ifdef DATA_PACK_LAST_EN
  localparam int CW = cnt_w(RATIO);
  logic                   in_last_i;
  logic                   out_last_o;
  logic [CW:0]            out_cnt_o;

  modport master (
    output in_data_i, in_valid_i, in_last_i, out_ready_i,
    input  in_ready_o, out_data_o, out_valid_o, out_last_o, out_cnt_o
  );
  modport slave (
    input  in_data_i, in_valid_i, in_last_i, out_ready_i,
    output in_ready_o, out_data_o, out_valid_o, out_last_o, out_cnt_o
  );
`else
  modport master (
    output in_data_i, in_valid_i, out_ready_i,
    input  in_ready_o, out_data_o, out_valid_o
  );
  modport slave (
    input  in_data_i, in_valid_i, out_ready_i,
    output in_ready_o, out_data_o, out_valid_o
  );
`endif

endinterface

// File: rtl/data_hs.sv
// Single-entry valid/ready output register: loads when empty or being drained.
module data_hs #(
  parameter int W = 32
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic [W-1:0] in_data_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  output logic [W-1:0] out_data_o,
  output logic         out_valid_o,
  input  logic         out_ready_i
);

  logic         r_valid;
  logic [W-1:0] r_data;

  assign in_ready_o  = out_ready_i | ~r_valid;
  assign out_data_o  = r_data;
  assign out_valid_o = r_valid;

  // A simultaneous drain and load keeps valid high with the new word.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_valid <= 1'b0;
      r_data  <= '0;
    end else if (in_valid_i && in_ready_o) begin
      r_valid <= 1'b1;
      r_data  <= in_data_i;
    end else if (out_ready_i) begin
      r_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/data_pack.sv
// Packs RATIO narrow words (first word in the LSBs) into one wide word.
// DATA_PACK_LAST_EN lets in_last_i close a group early, zero-filling the upper words.
module data_pack
  import hdl_utils_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int RATIO = 4
) (
  input logic         clk_i,
  input logic         rst_n_i,
  data_pack_if.slave  bus
);

  localparam int CW = cnt_w(RATIO);
  localparam int TW = WIDTH * RATIO;
  localparam int AW = (RATIO - 1) * WIDTH;
`ifdef DATA_PACK_LAST_EN
  localparam int HW = TW + CW + 2;
`else
  localparam int HW = TW;
`endif

  logic [CW-1:0] r_cnt;
  logic [AW-1:0] r_acc;

  logic          w_last_word;
  logic          w_hs_ready;
  logic          w_hs_valid;
  logic          w_xfer;
  logic [31:0]   w_shamt;
  logic [TW-1:0] w_in_shift;
  logic [TW-1:0] w_packed;
  logic [HW-1:0] w_hs_in;
  logic [HW-1:0] w_hs_out;

`ifdef DATA_PACK_LAST_EN
  logic [CW:0]   w_cnt_p1;

  assign w_last_word = (r_cnt == CW'(RATIO - 1)) | bus.in_last_i;
  assign w_cnt_p1    = {1'b0, r_cnt} + {{CW{1'b0}}, 1'b1};
  assign w_hs_in     = {bus.in_last_i, w_cnt_p1, w_packed};
  assign bus.out_last_o = w_hs_out[HW-1];
  assign bus.out_cnt_o  = w_hs_out[TW +: CW+1];
`else
  assign w_last_word = (r_cnt == CW'(RATIO - 1));
  assign w_hs_in     = w_packed;
`endif

  // Only the group-closing word depends on the output register having room.
  assign bus.in_ready_o = w_last_word ? w_hs_ready : 1'b1;
  assign w_xfer         = bus.in_valid_i & bus.in_ready_o;
  assign w_hs_valid     = bus.in_valid_i & w_last_word;

  // Accumulator slots above r_cnt are always zero, so OR-merging places the new word.
  assign w_shamt    = 32'(r_cnt) * WIDTH;
  assign w_in_shift = {{AW{1'b0}}, bus.in_data_i} << w_shamt;
  assign w_packed   = {{WIDTH{1'b0}}, r_acc} | w_in_shift;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_cnt <= '0;
      r_acc <= '0;
    end else if (w_xfer) begin
      if (w_last_word) begin
        r_cnt <= '0;
        r_acc <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
        r_acc <= r_acc | w_in_shift[AW-1:0];
      end
    end
  end

  data_hs #(.W(HW)) u_out (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .in_data_i   (w_hs_in),
    .in_valid_i  (w_hs_valid),
    .in_ready_o  (w_hs_ready),
    .out_data_o  (w_hs_out),
    .out_valid_o (bus.out_valid_o),
    .out_ready_i (bus.out_ready_i)
  );

  assign bus.out_data_o = w_hs_out[TW-1:0];

endmodule

// File: doc/data_pack.md
DATA_PACK -- requirements
Module: data_pack

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the input word width in bits.
REQ-002 The block SHALL have parameter RATIO, default 4, giving input words per output word; legal range 2..16.
REQ-003 The block SHALL have port clk_i, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n_i, input, 1 bit: reset, asynchronous and active-low.
REQ-005 The block SHALL have port in_data_i, input, WIDTH bits: narrow input word.
REQ-006 The block SHALL have port in_valid_i, input, 1 bit: input word present.
REQ-007 The block SHALL have port in_ready_o, output, 1 bit: block accepts the input word this cycle.
REQ-008 The block SHALL have port out_data_o, output, WIDTH*RATIO bits: packed output word.
REQ-009 The block SHALL have port out_valid_o, output, 1 bit: packed word present.
REQ-010 The block SHALL have port out_ready_i, input, 1 bit: consumer accepts the packed word.

Function
REQ-011 An input transfer SHALL occur in a cycle with in_valid_i and in_ready_o both high; an output transfer SHALL occur in a cycle with out_valid_o and out_ready_i both high.
REQ-012 Word k of a group (k = 0..RATIO-1, in arrival order) SHALL occupy out_data_o[k*WIDTH +: WIDTH], i.e. first word in the LSBs.
REQ-013 A fill counter cnt, width $clog2(RATIO), SHALL count accepted words of the current group; it wraps from RATIO-1 to 0 on the accepting transfer.
REQ-014 Words 0..RATIO-2 SHALL be stored in an accumulation register and accepted unconditionally: in_ready_o is high whenever cnt != RATIO-1.
REQ-015 When cnt == RATIO-1, in_ready_o SHALL equal out_ready_i | ~out_valid_o.
REQ-016 On acceptance of word RATIO-1, the output register SHALL load {in_data_i, accumulated words} and out_valid_o SHALL go high the next cycle: latency one cycle from the last word.
REQ-017 out_valid_o SHALL clear after an output transfer unless a new group completes in the same cycle, in which case it stays high with the new data.
REQ-018 While out_valid_o is high and out_ready_i is low, out_data_o and out_valid_o SHALL hold unchanged.
REQ-019 With in_valid_i held high and out_ready_i held high, throughput SHALL be one input word per cycle with no bubbles.
REQ-020 Input words presented while in_valid_i is low SHALL not affect state.

Reset
REQ-021 While rst_n_i is low, cnt, the accumulation register, out_data_o and out_valid_o SHALL be zero.
REQ-022 A reset asserted mid-group SHALL discard the partial group; the first word after reset is word 0.

Configuration
REQ-023 With macro DATA_PACK_LAST_EN defined, ports in_last_i (input, 1), out_last_o (output, 1) and out_cnt_o (output, $clog2(RATIO)+1) SHALL exist.
REQ-024 With DATA_PACK_LAST_EN, an accepted word with in_last_i high SHALL complete the group early, and the unfilled upper words of the packed word SHALL be zero.
REQ-025 With DATA_PACK_LAST_EN, out_last_o SHALL be high on an early-completed group, and also on a full group whose final word carried in_last_i.
REQ-026 With DATA_PACK_LAST_EN, out_cnt_o SHALL give the number of valid words, 1..RATIO.
REQ-027 With DATA_PACK_LAST_EN, any word carrying in_last_i SHALL follow the cnt == RATIO-1 ready rule of REQ-015.
REQ-028 Without DATA_PACK_LAST_EN, those three ports SHALL be absent and every group SHALL be exactly RATIO words.

Structure
REQ-029 A shared package hdl_utils_pkg SHALL hold a function returning the counter width for a given RATIO; no other typedefs are needed.
REQ-030 The output register SHALL be one instance of data_hs, width WIDTH*RATIO (plus last and cnt bits when DATA_PACK_LAST_EN), with its in_valid_i driven by "last-word transfer".

Verification
REQ-031 Bench: WIDTH=8, RATIO=4; reset, then feed 0x11,0x22,0x33,0x44 back-to-back with out_ready_i=1 -> one cycle after the 4th word, out_data_o=0x44332211 and out_valid_o=1 for exactly one cycle.
REQ-032 Bench: continuous stream 0x00..0x0F with out_ready_i=1 -> outputs 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C, with in_ready_o never low.
REQ-033 Bench: hold out_ready_i=0 after the first group -> words 4..6 accepted, in_ready_o=0 at word 7, first packed word stable; release -> 0x07060504 follows with no lost or duplicated word.
REQ-034 Bench: assert rst_n_i asynchronously after 2 words of a group -> outputs zero immediately; then feed 0xA0..0xA3 -> 0xA3A2A1A0.
REQ-035 Bench (DATA_PACK_LAST_EN): feed 0x55,0x66 with in_last_i on 0x66 -> out_data_o=0x00006655, out_cnt_o=2, out_last_o=1.
